// File: rtl/parity_word_serializer.sv
// Serializes one odd-parity-protected word into an idle-high frame: start bit, LSB-first data, stop bit.
// Each serial bit lasts CLKS_PER_BIT cycles. wordReady is high only in IDLE, so upstream holds its word while a frame is in progress.
module parity_word_serializer #(
  parameter int WORD_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] wordIn,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic                  serialOut,
  output logic                  busy,
  output logic                  parityError,
  output logic                  txDone
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  par_err_q, par_err_d;
  logic                  tx_done_q, tx_done_d;
  logic                  accept;
  logic                  bit_end;

  assign wordReady = (state_q == IDLE) && rst_n;
  assign accept    = wordValid && wordReady;
  assign bit_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    par_err_d = 1'b0;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          state_d   = START;
          shift_d   = wordIn;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          serial_d  = 1'b0;
          par_err_d = ~(^wordIn);
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          serial_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BW'(WORD_WIDTH - 1)) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            serial_d  = 1'b1;
          end else begin
            // Next bit goes out on the same edge that shifts it into position 0.
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          serial_d  = 1'b1;
          tx_done_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      par_err_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      par_err_q <= par_err_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign serialOut   = serial_q;
  assign busy        = busy_q;
  assign parityError = par_err_q;
  assign txDone      = tx_done_q;

endmodule

// File: tb/tb_parity_word_serializer.sv
// Bench for parity_word_serializer: one instance at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1.
module tb_parity_word_serializer;

  localparam int W = 16;
  localparam int P = 10;

  logic clk = 1'b0;
  always #(P/2) clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  w4, w1;
  logic          v4, v1;
  logic          r4, s4, b4, pe4, td4;
  logic          r1, s1, b1, pe1, td1;

  parity_word_serializer #(.WORD_WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wordIn(w4), .wordValid(v4), .wordReady(r4),
    .serialOut(s4), .busy(b4), .parityError(pe4), .txDone(td4));

  parity_word_serializer #(.WORD_WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wordIn(w1), .wordValid(v1), .wordReady(r1),
    .serialOut(s1), .busy(b1), .parityError(pe1), .txDone(td1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Output bundle {ready, serial, busy, parityError, txDone} of the selected instance.
  function automatic logic [4:0] outs(input bit sel);
    return sel ? {r1, s1, b1, pe1, td1} : {r4, s4, b4, pe4, td4};
  endfunction

  task automatic drive(input bit sel, input logic [W-1:0] w, input logic v);
    if (sel) begin w1 = w; v1 = v; end
    else     begin w4 = w; v4 = v; end
  endtask

  // mode 0: drop valid after accept; mode 1: scramble wordIn with valid high during the frame;
  // mode 2: present next_w with valid held high so the next accept follows the idle cycle.
  task automatic run_frame(input string tag, input bit sel, input logic [W-1:0] w,
                           input logic exp_perr, input int mode, input logic [W-1:0] next_w,
                           output longint t_acc);
    int cpb;
    int len;
    int i;
    logic exp_ser[$];
    logic [4:0] o;
    cpb = sel ? 1 : 4;
    len = (W + 2) * cpb;
    for (int k = 0; k < cpb; k++) exp_ser.push_back(1'b0);
    for (int b = 0; b < W; b++)
      for (int k = 0; k < cpb; k++) exp_ser.push_back(w[b]);
    for (int k = 0; k < cpb; k++) exp_ser.push_back(1'b1);

    t_acc = 0;
    drive(sel, w, 1'b1);
    i = 0;
    while (!outs(sel)[4] && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) begin
      chk({tag, " accept_timeout"}, 32'd0, 32'd1);
      drive(sel, w, 1'b0);
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    if (mode == 0) drive(sel, w, 1'b0);
    if (mode == 2) drive(sel, next_w, 1'b1);

    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = outs(sel);
      chk($sformatf("%s ser[%0d]", tag, k), 32'(o[3]), 32'(exp_ser[k-1]));
      chk($sformatf("%s busy[%0d]", tag, k), 32'(o[2]), 32'd1);
      chk($sformatf("%s ready[%0d]", tag, k), 32'(o[4]), 32'd0);
      chk($sformatf("%s perr[%0d]", tag, k), 32'(o[1]), (k == 1) ? 32'(exp_perr) : 32'd0);
      chk($sformatf("%s txdone[%0d]", tag, k), 32'(o[0]), 32'd0);
      if (mode == 1) drive(sel, W'($urandom), 1'b1);
    end

    @(negedge clk);
    o = outs(sel);
    chk({tag, " txdone_pulse"}, 32'(o[0]), 32'd1);
    chk({tag, " idle_busy"}, 32'(o[2]), 32'd0);
    chk({tag, " idle_ready"}, 32'(o[4]), 32'd1);
    chk({tag, " idle_ser"}, 32'(o[3]), 32'd1);
    if (mode == 1) drive(sel, w, 1'b0);
    if (mode != 2) begin
      @(negedge clk);
      o = outs(sel);
      chk({tag, " txdone_once"}, 32'(o[0]), 32'd0);
      chk({tag, " stays_idle"}, 32'(o[2]), 32'd0);
    end
  endtask

  typedef struct {
    string        name;
    bit           sel;
    logic [W-1:0] word;
    logic         exp_perr;
  } vec_t;

  vec_t vecs[6];
  longint t1, t2;
  logic [W-1:0] rw;
  bit rsel;
  int seen_td;

  initial begin
    vecs[0] = '{"w0001_c4", 1'b0, 16'h0001, 1'b0};
    vecs[1] = '{"wA5A5_c4", 1'b0, 16'hA5A5, 1'b1};
    vecs[2] = '{"w0003_c1", 1'b1, 16'h0003, 1'b1};
    vecs[3] = '{"wFFFF_c4", 1'b0, 16'hFFFF, 1'b1};
    vecs[4] = '{"w7FFF_c1", 1'b1, 16'h7FFF, 1'b0};
    vecs[5] = '{"w8000_c4", 1'b0, 16'h8000, 1'b0};

    rst_n = 1'b0;
    w4 = '0; v4 = 1'b0; w1 = '0; v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready4", 32'(r4), 32'd0);
    chk("rst_ser4", 32'(s4), 32'd1);
    chk("rst_busy4", 32'(b4), 32'd0);
    chk("rst_pulses4", {30'd0, pe4, td4}, 32'd0);
    chk("rst_ready1", 32'(r1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready4", 32'(r4), 32'd1);
    chk("post_rst_ser1", 32'(s1), 32'd1);

    // Table of directed words.
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].name, vecs[i].sel, vecs[i].word, vecs[i].exp_perr, 0, '0, t1);

    // Back-to-back: valid held high, second word queued behind the first.
    run_frame("b2b_first", 1'b0, 16'h0001, 1'b0, 2, 16'h8000, t1);
    run_frame("b2b_second", 1'b0, 16'h8000, 1'b0, 0, '0, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'(73 * P));

    // wordIn scrambled during the frame must not affect the transmitted word.
    run_frame("scramble", 1'b0, 16'h5A3C, ($countones(16'h5A3C) % 2) == 0, 1, '0, t1);

    // Randomized words on both instances, parity expectation from the bit count.
    for (int i = 0; i < 12; i++) begin
      rw   = W'($urandom);
      rsel = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", i), rsel, rw, ($countones(rw) % 2) == 0,
                int'($urandom_range(0, 1)), '0, t1);
    end

    // Asynchronous reset during data bit 7.
    @(negedge clk);
    drive(0, 16'h1234, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'h1234, 1'b0);
    repeat (34) @(negedge clk);
    chk("midrst_busy_before", 32'(b4), 32'd1);
    chk("midrst_ser_before", 32'(s4), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser", 32'(s4), 32'd1);
    chk("midrst_busy", 32'(b4), 32'd0);
    chk("midrst_ready", 32'(r4), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_pulses", {30'd0, pe4, td4}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", 32'(r4), 32'd1);
    seen_td = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (td4 || pe4 || b4) seen_td++;
    end
    chk("midrst_no_frame_after", 32'(seen_td), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_word_serializer.md
Name: parity_word_serializer

Overview:
- Sits directly downstream of the odd-parity encoder.
- Accepts one 16-bit parity-protected word (bits 15:1 payload, bit 0 odd-parity bit) through a valid/ready handshake.
- Re-checks odd parity on the captured word.
- Shifts the word out on a single serial line in an idle-high frame: start bit, data LSB first, stop bit.

Parameters:
- WORD_WIDTH, 16, width of the incoming parity-protected word. It includes the parity bit at bit 0.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held. Legal range is 1 or greater.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wordIn  input  WORD_WIDTH  parity-protected word from the encoder.
- wordValid  input  1  wordIn is valid this cycle.
- wordReady  output  1  block can accept a word this cycle.
- serialOut  output  1  serial line, registered, idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- parityError  output  1  one-cycle pulse when the accepted word fails the odd-parity check.
- txDone  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state to IDLE;
  - serialOut to 1;
  - busy, parityError and txDone to 0;
  - shift register and bit/clock counters to 0.
- wordReady is 0 while rst_n is low.
- wordReady = (state == IDLE) and rst_n high. It is combinational from the state register.
- Accept occurs on a rising edge where wordValid and wordReady are both 1.
  - wordIn is captured into the shift register at that edge.
  - wordIn changes after the accept edge are ignored.
- Parity check at accept:
  - XOR of all WORD_WIDTH bits of wordIn must be 1 (odd parity).
  - If it is 0, parityError is 1 for exactly the cycle after the accept edge.
  - The word is still transmitted unchanged.
- States:
  - IDLE: serialOut = 1. On accept, go to START.
  - START: serialOut = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: serialOut = shift[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After WORD_WIDTH bits, go to STOP.
  - STOP: serialOut = 1 for CLKS_PER_BIT cycles, then go to IDLE. txDone is 1 for the first IDLE cycle.
- Timing:
  - serialOut is registered and changes on the edge that enters each state or bit.
  - The first start-bit cycle is the cycle after the accept edge.
  - Frame length is (WORD_WIDTH+2)*CLKS_PER_BIT cycles.
  - At least one IDLE cycle (line high, wordReady high) separates consecutive frames.
  - Back-to-back accepts are therefore (WORD_WIDTH+2)*CLKS_PER_BIT+1 cycles apart.
- Counters:
  - The clock counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit counter counts 0..WORD_WIDTH-1.
  - Both reset to 0 on every state entry.
  - With CLKS_PER_BIT = 1, each state or bit lasts exactly one cycle.
- busy is 1 in START, DATA and STOP, and 0 in IDLE.
- wordValid while not ready: no capture, no state change. The upstream stage holds its word.
- Reset mid-frame:
  - The frame is aborted immediately (asynchronous) and serialOut returns to 1.
  - No txDone or parityError pulse is emitted for the aborted frame.
  - wordReady is 1 from the first clock edge after rst_n rises.

Test Plan:
- CLKS_PER_BIT=4, accept wordIn=16'h0001 (odd, valid) -> parityError stays 0; serialOut is 0 for 4 cycles, 1 for 4, 0 for 60, 1 for 4; txDone pulses once 73 cycles after accept; busy is high for 72 cycles.
- Accept 16'hA5A5 (even, invalid) -> parityError pulses 1 cycle after accept; data bits LSB first are 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, each held 4 cycles.
- wordValid held high with 16'h0001 then 16'h8000 -> second accept occurs exactly 73 cycles after the first; serialOut is high for exactly one cycle between the frames; wordReady is low for cycles 1-72 of each frame.
- Assert rst_n low during data bit 7 of a frame -> serialOut goes to 1 and busy to 0 without waiting for a clock edge; no txDone; wordReady is 1 on the first edge after release.
- Change wordIn every cycle during a frame with wordValid high -> transmitted bits match the word captured at accept; no additional accept until IDLE.
- CLKS_PER_BIT=1, accept 16'h0003 (even, invalid) -> parityError pulses; 18-cycle frame with serial sequence 0,1,1,0×14,1; txDone pulses 19 cycles after accept.
